countdown_timer: RTL and testbench

//   Loadable MM:SS down-counter (kitchen/snooze timer) for the alarm clock datapath.

---
 rtl/countdown_timer.sv | 106 ++++++++++
 tb/tb_countdown_timer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable MM:SS down-counter: counts toward 00:00 on each tick strobe while running,
// raises a held expired flag and a one-cycle done_pulse on reaching zero. All outputs registered.
module countdown_timer #(
  parameter int MIN_W   = 7,
  parameter int MAX_MIN = 99,
  parameter int SEC_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             ack,
  output logic [MIN_W-1:0] min_out,
  output logic [SEC_W-1:0] sec_out,
  output logic             running,
  output logic             expired,
  output logic             done_pulse,
  output logic             load_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t state;
  logic   count_zero;
  logic   load_bad;

  assign count_zero = (min_out == '0) && (sec_out == '0);
  assign load_bad   = (load_sec > SEC_W'(59)) || (load_min > MIN_W'(MAX_MIN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      min_out    <= '0;
      sec_out    <= '0;
      running    <= 1'b0;
      expired    <= 1'b0;
      done_pulse <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      load_err   <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        min_out <= '0;
        sec_out <= '0;
        running <= 1'b0;
        expired <= 1'b0;
      end else begin
        case (state)
          IDLE, PAUSED: begin
            // pause outranks start, so pause+start in PAUSED leaves us paused
            if (load) begin
              if (load_bad) begin
                load_err <= 1'b1;
              end else begin
                min_out <= load_min;
                sec_out <= load_sec;
              end
            end else if (!pause && start && !count_zero) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (tick) begin
              if (sec_out != '0) begin
                sec_out <= sec_out - SEC_W'(1);
                if (sec_out == SEC_W'(1) && min_out == '0) begin
                  state      <= EXPIRED;
                  running    <= 1'b0;
                  expired    <= 1'b1;
                  done_pulse <= 1'b1;
                end
              end else begin
                sec_out <= SEC_W'(59);
                min_out <= min_out - MIN_W'(1);
              end
            end
          end
          EXPIRED: begin
            if (ack) begin
              state   <= IDLE;
              expired <= 1'b0;
              min_out <= '0;
              sec_out <= '0;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: hand-computed expected counts and flags after each step.
module tb_countdown_timer;

  logic       clk, reset, tick, load, start, pause, clear, ack;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic [6:0] min_out;
  logic [5:0] sec_out;
  logic       running, expired, done_pulse, load_err;

  int n_chk  = 0;
  int n_fail = 0;

  countdown_timer #(.MIN_W(7), .MAX_MIN(99), .SEC_W(6)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_min(load_min),
    .load_sec(load_sec), .start(start), .pause(pause), .clear(clear), .ack(ack),
    .min_out(min_out), .sec_out(sec_out), .running(running), .expired(expired),
    .done_pulse(done_pulse), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    tick = 0; load = 0; start = 0; pause = 0; clear = 0; ack = 0;
  endtask

  task automatic chk_state(input string tag, input int m, input int s, input int run, input int exp_f);
    check({tag, ".min"}, int'(min_out), m);
    check({tag, ".sec"}, int'(sec_out), s);
    check({tag, ".running"}, int'(running), run);
    check({tag, ".expired"}, int'(expired), exp_f);
  endtask

  task automatic do_load(input int m, input int s);
    load = 1; load_min = 7'(m); load_sec = 6'(s);
    cyc();
  endtask

  initial begin
    reset = 1; tick = 0; load = 0; start = 0; pause = 0; clear = 0; ack = 0;
    load_min = '0; load_sec = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk_state("reset", 0, 0, 0, 0);
    check("reset.done", int'(done_pulse), 0);
    check("reset.err", int'(load_err), 0);

    // T2: load 01:02, start, three ticks with borrow
    do_load(1, 2);
    chk_state("t2.load", 1, 2, 0, 0);
    start = 1; cyc();
    check("t2.start.running", int'(running), 1);
    tick = 1; cyc(); chk_state("t2.tick1", 1, 1, 1, 0);
    cyc();
    tick = 1; cyc(); chk_state("t2.tick2", 1, 0, 1, 0);
    tick = 1; cyc(); chk_state("t2.borrow", 0, 59, 1, 0);

    // T3: run down to expiry
    for (int i = 0; i < 58; i++) begin
      tick = 1; cyc(); cyc();
    end
    chk_state("t3.0001", 0, 1, 1, 0);
    check("t3.nodone", int'(done_pulse), 0);
    tick = 1; cyc();
    chk_state("t3.zero", 0, 0, 0, 1);
    check("t3.done", int'(done_pulse), 1);
    tick = 1; start = 1; load = 1; load_min = 7'd5; load_sec = 6'd0; cyc();
    chk_state("t3.held", 0, 0, 0, 1);
    check("t3.done_once", int'(done_pulse), 0);
    check("t3.noerr", int'(load_err), 0);
    ack = 1; cyc();
    chk_state("t3.ack", 0, 0, 0, 0);

    // T4: rejected and boundary loads
    do_load(2, 3);
    do_load(0, 60);
    check("t4.err_sec", int'(load_err), 1);
    chk_state("t4.unchanged", 2, 3, 0, 0);
    cyc();
    check("t4.err_clr", int'(load_err), 0);
    do_load(100, 0);
    check("t4b.err_min", int'(load_err), 1);
    chk_state("t4b.unchanged", 2, 3, 0, 0);
    do_load(99, 59);
    check("t4.max_ok", int'(load_err), 0);
    chk_state("t4.max", 99, 59, 0, 0);

    // T4c: load during RUN is ignored silently
    do_load(0, 10);
    start = 1; tick = 1; cyc();
    chk_state("t4c.enter_run", 0, 10, 1, 0);
    do_load(5, 5);
    check("t4c.noerr", int'(load_err), 0);
    chk_state("t4c.ignored", 0, 10, 1, 0);

    // T5: pause with same-cycle tick drops the tick
    pause = 1; tick = 1; cyc();
    chk_state("t5.paused", 0, 10, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick = 1; cyc();
    end
    chk_state("t5b.frozen", 0, 10, 0, 0);
    start = 1; tick = 1; cyc();
    chk_state("t5b.resume", 0, 10, 1, 0);
    tick = 1; cyc();
    chk_state("t5b.count", 0, 9, 1, 0);
    pause = 1; cyc();
    start = 1; pause = 1; cyc();
    chk_state("t5c.stay_paused", 0, 9, 0, 0);
    do_load(0, 5);
    chk_state("t5.load_paused", 0, 5, 0, 0);

    // T6: clear from RUN, start at zero, clear from PAUSED and EXPIRED
    start = 1; cyc();
    check("t6.run", int'(running), 1);
    clear = 1; tick = 1; cyc();
    chk_state("t6.clear_run", 0, 0, 0, 0);
    start = 1; cyc();
    chk_state("t6.start_zero", 0, 0, 0, 0);
    do_load(0, 3);
    start = 1; cyc(); pause = 1; cyc();
    clear = 1; cyc();
    chk_state("t6.clear_paused", 0, 0, 0, 0);
    do_load(0, 1);
    start = 1; cyc();
    clear = 1; tick = 1; cyc();
    chk_state("t6.clear_beats_tick", 0, 0, 0, 0);
    check("t6.no_done", int'(done_pulse), 0);
    do_load(0, 1);
    start = 1; cyc(); tick = 1; cyc();
    check("t6.expired", int'(expired), 1);
    clear = 1; cyc();
    chk_state("t6.clear_expired", 0, 0, 0, 0);

    // T6b: ack outside EXPIRED has no effect
    do_load(0, 4);
    ack = 1; cyc();
    chk_state("t6b.ack_idle", 0, 4, 0, 0);

    // T1: asynchronous reset in the middle of RUN at 01:30
    do_load(1, 30);
    start = 1; cyc();
    tick = 1; cyc();
    chk_state("t1.pre", 1, 29, 1, 0);
    #2 reset = 1;
    #1;
    chk_state("t1.async", 0, 0, 0, 0);
    check("t1.done", int'(done_pulse), 0);
    check("t1.err", int'(load_err), 0);
    #1 reset = 0;
    start = 1; cyc();
    chk_state("t1.idle_after", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
